// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised dual-port RAM.
package ram_pkg;

    localparam int unsigned RAM_BYTE = 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } ram_state_t;

    // True when addr names a word that exists; DEPTH need not be a power of two.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/ram_dp_core.sv
// Storage array: byte-enabled synchronous write, synchronous read, no array reset.
module ram_dp_core
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned BE_W   = DATA_W / RAM_BYTE
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   wbe,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < int'(BE_W); k++) begin
                if (wbe[k]) mem[waddr][k*RAM_BYTE +: RAM_BYTE] <= wdata[k*RAM_BYTE +: RAM_BYTE];
            end
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/ram_dp_param.sv
// Simple-dual-port RAM with clear engine, range checks, write-first bypass and
// configurable read latency.
module ram_dp_param
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned BE_W     = DATA_W / RAM_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ram_state_t        state;
    logic [ADDR_W-1:0] ptr;

    logic              wr_in, rd_in, rd_acc, err_c;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_wbe;
    logic [DATA_W-1:0] core_q;

    logic              v1, zero1, have1;
    logic [BE_W-1:0]   byp_be1;
    logic [DATA_W-1:0] byp_data1;
    logic [DATA_W-1:0] rd_word;

    // Access qualification and error detection.
    always_comb begin
        wr_in  = addr_in_range(32'(wr_addr), DEPTH);
        rd_in  = addr_in_range(32'(rd_addr), DEPTH);
        rd_acc = (state == ST_RUN) && rd_en;
        err_c  = 1'b0;
        if (state == ST_CLEAR) err_c = wr_en || rd_en;
        else                   err_c = (wr_en && !wr_in) || (rd_en && !rd_in);
    end

    // Write port: the clear engine owns the port while clearing.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        mem_wbe   = wr_be;
        if (state == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = ptr;
            mem_wdata = '0;
            mem_wbe   = '1;
        end else if (wr_en && wr_in) begin
            mem_we = 1'b1;
        end
    end

    // Clear FSM, pointer and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
            err   <= 1'b0;
        end else begin
            err <= err_c;
            case (state)
                ST_CLEAR: begin
                    ptr <= ptr + ADDR_W'(1);
                    if (ptr == LAST_ADDR) begin
                        state <= ST_RUN;
                        busy  <= 1'b0;
                        ptr   <= '0;
                    end
                end
                ST_RUN: begin
                    if (clr) begin
                        state <= ST_CLEAR;
                        busy  <= 1'b1;
                        ptr   <= '0;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    ram_dp_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .BE_W   (BE_W)
    ) u_core (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .wbe   (mem_wbe),
        .re    (rd_acc && rd_in),
        .raddr (rd_addr),
        .rdata (core_q)
    );

    // First read stage: remembers which bytes the same-cycle write overrides.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1        <= 1'b0;
            zero1     <= 1'b0;
            have1     <= 1'b0;
            byp_be1   <= '0;
            byp_data1 <= '0;
        end else begin
            v1 <= rd_acc;
            if (rd_acc) begin
                have1     <= 1'b1;
                zero1     <= !rd_in;
                byp_be1   <= (wr_en && wr_in && (wr_addr == rd_addr)) ? wr_be : '0;
                byp_data1 <= wr_data;
            end
        end
    end

    always_comb begin
        rd_word = core_q;
        for (int k = 0; k < int'(BE_W); k++) begin
            if (byp_be1[k]) rd_word[k*RAM_BYTE +: RAM_BYTE] = byp_data1[k*RAM_BYTE +: RAM_BYTE];
        end
        if (zero1 || !have1) rd_word = '0;
    end

    generate
        if (READ_LAT == 1) begin : g_lat1
            assign rd_data  = rd_word;
            assign rd_valid = v1;
        end else begin : g_lat2
            logic [DATA_W-1:0] rd_q;
            logic              v2;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rd_q <= '0;
                    v2   <= 1'b0;
                end else begin
                    v2 <= v1;
                    if (v1) rd_q <= rd_word;
                end
            end
            assign rd_data  = rd_q;
            assign rd_valid = v2;
        end
    endgenerate

endmodule

// File: tb/tb_ram_dp_param.sv
// Directed bench for ram_dp_param: 8-bit/64-word/latency-1 and 32-bit/48-word/latency-2 instances.
module tb_ram_dp_param;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        a_clr, a_busy, a_wr_en, a_rd_en, a_rd_valid, a_err;
    logic [5:0]  a_wr_addr, a_rd_addr;
    logic [7:0]  a_wr_data, a_rd_data;
    logic [0:0]  a_wr_be;

    logic        b_clr, b_busy, b_wr_en, b_rd_en, b_rd_valid, b_err;
    logic [5:0]  b_wr_addr, b_rd_addr;
    logic [31:0] b_wr_data, b_rd_data;
    logic [3:0]  b_wr_be;

    ram_dp_param #(.DATA_W(8), .DEPTH(64), .READ_LAT(1)) u_a (
        .clk(clk), .rst(rst), .clr(a_clr), .busy(a_busy),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_be(a_wr_be),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .rd_valid(a_rd_valid), .err(a_err)
    );

    ram_dp_param #(.DATA_W(32), .DEPTH(48), .READ_LAT(2)) u_b (
        .clk(clk), .rst(rst), .clr(b_clr), .busy(b_busy),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_be(b_wr_be),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .err(b_err)
    );

    task automatic idle();
        a_clr = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0; a_wr_be = 1'b1;
        a_wr_addr = '0; a_rd_addr = '0; a_wr_data = '0;
        b_clr = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0; b_wr_be = 4'hF;
        b_wr_addr = '0; b_rd_addr = '0; b_wr_data = '0;
    endtask

    task automatic b_wr(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] be);
        b_wr_en = 1'b1; b_wr_addr = addr; b_wr_data = data; b_wr_be = be;
        @(negedge clk);
        b_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        int ca, cb, n;
        idle();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL rst_a_busy got=%b exp=1", a_busy); end
        checks++; if (b_busy !== 1'b1) begin failures++; $display("FAIL rst_b_busy got=%b exp=1", b_busy); end
        checks++; if (a_rd_valid !== 1'b0 || a_err !== 1'b0) begin failures++; $display("FAIL rst_a_flags got=%b%b exp=00", a_rd_valid, a_err); end
        checks++; if (a_rd_data !== 8'h00) begin failures++; $display("FAIL rst_a_data got=%h exp=00", a_rd_data); end
        checks++; if (b_rd_data !== 32'h0 || b_rd_valid !== 1'b0) begin failures++; $display("FAIL rst_b_out got=%h/%b exp=0/0", b_rd_data, b_rd_valid); end
        rst = 1'b1;
        ca = 0; cb = 0; n = 0;
        while ((a_busy || b_busy) && n < 200) begin
            if (a_busy) ca++;
            if (b_busy) cb++;
            n++;
            @(negedge clk);
        end
        checks++; if (ca != 64) begin failures++; $display("FAIL reset_clear_a_cycles got=%0d exp=64", ca); end
        checks++; if (cb != 48) begin failures++; $display("FAIL reset_clear_b_cycles got=%0d exp=48", cb); end
    endtask

    task automatic test_read_all_zero();
        for (int i = 0; i <= 64; i++) begin
            a_rd_en = (i < 64); a_rd_addr = 6'(i);
            @(negedge clk);
            if (i < 64) begin
                checks++;
                if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h00 || a_err !== 1'b0) begin
                    failures++; $display("FAIL read_zero addr=%0d got=%h v=%b e=%b exp=00 v=1 e=0", i, a_rd_data, a_rd_valid, a_err);
                end
            end else begin
                checks++; if (a_rd_valid !== 1'b0) begin failures++; $display("FAIL read_zero_end valid got=%b exp=0", a_rd_valid); end
            end
        end
        a_rd_en = 1'b0;
    endtask

    task automatic test_byte_enable();
        b_wr(6'd5, 32'hDEADBEEF, 4'b1111);
        b_wr(6'd5, 32'h11223344, 4'b0101);
        b_rd_en = 1'b1; b_rd_addr = 6'd5;
        @(negedge clk);
        b_rd_en = 1'b0;
        checks++; if (b_rd_valid !== 1'b0) begin failures++; $display("FAIL be_lat_early got=%b exp=0", b_rd_valid); end
        @(negedge clk);
        checks++; if (b_rd_valid !== 1'b1 || b_rd_data !== 32'hDE22BE44) begin failures++; $display("FAIL be_merge got=%h v=%b exp=DE22BE44 v=1", b_rd_data, b_rd_valid); end
        @(negedge clk);
        checks++; if (b_rd_valid !== 1'b0 || b_rd_data !== 32'hDE22BE44) begin failures++; $display("FAIL be_hold got=%h v=%b exp=DE22BE44 v=0", b_rd_data, b_rd_valid); end
    endtask

    task automatic test_bypass();
        a_wr_en = 1'b1; a_wr_addr = 6'd3; a_wr_data = 8'hA5; a_wr_be = 1'b1;
        a_rd_en = 1'b1; a_rd_addr = 6'd3;
        @(negedge clk);
        idle();
        checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 8'hA5) begin failures++; $display("FAIL bypass_new got=%h v=%b exp=A5 v=1", a_rd_data, a_rd_valid); end
        a_wr_en = 1'b1; a_wr_addr = 6'd7; a_wr_data = 8'h5A; a_wr_be = 1'b0;
        a_rd_en = 1'b1; a_rd_addr = 6'd7;
        @(negedge clk);
        idle();
        checks++; if (a_rd_data !== 8'h00) begin failures++; $display("FAIL bypass_be0 got=%h exp=00", a_rd_data); end
        a_rd_en = 1'b1; a_rd_addr = 6'd3;
        @(negedge clk);
        a_rd_en = 1'b0;
        checks++; if (a_rd_data !== 8'hA5) begin failures++; $display("FAIL bypass_stored got=%h exp=A5", a_rd_data); end
        b_wr_en = 1'b1; b_wr_addr = 6'd5; b_wr_data = 32'hAABBCCDD; b_wr_be = 4'b1001;
        b_rd_en = 1'b1; b_rd_addr = 6'd5;
        @(negedge clk);
        idle();
        @(negedge clk);
        checks++; if (b_rd_valid !== 1'b1 || b_rd_data !== 32'hAA22BEDD) begin failures++; $display("FAIL bypass_partial got=%h v=%b exp=AA22BEDD v=1", b_rd_data, b_rd_valid); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] exp;
        b_wr(6'd50, 32'h12345678, 4'hF);
        checks++; if (b_err !== 1'b1) begin failures++; $display("FAIL oor_wr_err got=%b exp=1", b_err); end
        b_rd_en = 1'b1; b_rd_addr = 6'd50;
        @(negedge clk);
        b_rd_en = 1'b0;
        checks++; if (b_err !== 1'b1 || b_rd_valid !== 1'b0) begin failures++; $display("FAIL oor_rd_err got=%b v=%b exp=1 v=0", b_err, b_rd_valid); end
        @(negedge clk);
        checks++; if (b_rd_valid !== 1'b1 || b_rd_data !== 32'h0 || b_err !== 1'b0) begin failures++; $display("FAIL oor_rd_data got=%h v=%b e=%b exp=0 v=1 e=0", b_rd_data, b_rd_valid, b_err); end
        for (int j = 0; j <= 48; j++) begin
            b_rd_en = (j < 48); b_rd_addr = 6'(j);
            @(negedge clk);
            if (j >= 1) begin
                exp = (j - 1 == 5) ? 32'hAA22BEDD : 32'h0;
                checks++;
                if (b_rd_valid !== 1'b1 || b_rd_data !== exp) begin
                    failures++; $display("FAIL oor_intact addr=%0d got=%h v=%b exp=%h", j - 1, b_rd_data, b_rd_valid, exp);
                end
            end
        end
        b_rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clear();
        int cnt;
        for (int i = 0; i < 64; i++) begin
            a_wr_en = 1'b1; a_wr_addr = 6'(i); a_wr_data = 8'hFF; a_wr_be = 1'b1;
            @(negedge clk);
        end
        idle();
        a_clr = 1'b1; a_rd_en = 1'b1; a_rd_addr = 6'd9;
        a_wr_en = 1'b1; a_wr_addr = 6'd1; a_wr_data = 8'h77;
        @(negedge clk);
        idle();
        checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 8'hFF) begin failures++; $display("FAIL clr_inflight got=%h v=%b exp=FF v=1", a_rd_data, a_rd_valid); end
        checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL clr_busy got=%b exp=1", a_busy); end
        cnt = 1;
        a_rd_en = 1'b1; a_rd_addr = 6'd2; a_clr = 1'b1;
        @(negedge clk);
        idle();
        cnt++;
        checks++; if (a_err !== 1'b1 || a_rd_valid !== 1'b0) begin failures++; $display("FAIL clr_busy_drop e=%b v=%b exp e=1 v=0", a_err, a_rd_valid); end
        @(negedge clk);
        checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL clr_err_single got=%b exp=0", a_err); end
        while (a_busy && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        checks++; if (cnt != 64) begin failures++; $display("FAIL clr_busy_cycles got=%0d exp=64", cnt); end
        for (int i = 0; i <= 64; i++) begin
            a_rd_en = (i < 64); a_rd_addr = 6'(i);
            @(negedge clk);
            if (i < 64) begin
                checks++;
                if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h00) begin
                    failures++; $display("FAIL clr_zero addr=%0d got=%h v=%b exp=00 v=1", i, a_rd_data, a_rd_valid);
                end
            end
        end
        a_rd_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        logic [31:0] exp_d;
        int n;
        for (int i = 0; i < 10; i++) b_wr(6'(i), 32'h10 + 32'(i), 4'hF);
        for (int j = 0; j < 13; j++) begin
            b_rd_en = (j < 10); b_rd_addr = 6'(j);
            @(negedge clk);
            exp_v = (j >= 1 && j <= 10);
            exp_d = 32'h10 + 32'(j - 1);
            checks++;
            if (b_rd_valid !== exp_v || (exp_v && b_rd_data !== exp_d)) begin
                failures++; $display("FAIL b2b step=%0d got=%h v=%b exp=%h v=%b", j, b_rd_data, b_rd_valid, exp_d, exp_v);
            end
        end
        for (int j = 0; j < 5; j++) begin
            b_rd_en = 1'b1; b_rd_addr = 6'(j);
            @(negedge clk);
        end
        checks++; if (b_rd_valid !== 1'b1 || b_rd_data !== 32'h13) begin failures++; $display("FAIL b2b_pre_rst got=%h v=%b exp=13 v=1", b_rd_data, b_rd_valid); end
        idle();
        rst = 1'b0;
        #1;
        checks++; if (b_rd_valid !== 1'b0 || b_rd_data !== 32'h0) begin failures++; $display("FAIL rst_mid_stream got=%h v=%b exp=0 v=0", b_rd_data, b_rd_valid); end
        checks++; if (b_busy !== 1'b1 || a_busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy a=%b b=%b exp=11", a_busy, b_busy); end
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (b_busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n != 48) begin failures++; $display("FAIL rst_reclear_cycles got=%0d exp=48", n); end
        b_rd_en = 1'b1; b_rd_addr = 6'd3;
        @(negedge clk);
        b_rd_en = 1'b0;
        @(negedge clk);
        checks++; if (b_rd_valid !== 1'b1 || b_rd_data !== 32'h0) begin failures++; $display("FAIL rst_reclear_data got=%h v=%b exp=0 v=1", b_rd_data, b_rd_valid); end
    endtask

    initial begin
        idle();
        test_reset();
        test_read_all_zero();
        test_byte_enable();
        test_bypass();
        test_out_of_range();
        test_clear();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_dp_param.md
# ram_dp_param

Parametrised single-clock simple-dual-port RAM: one write port with byte enables and one read port with configurable latency. It adds a sequential memory-clear engine that runs after reset and on request, range checking, and a read-valid strobe. It serves as the general storage block for datapath buffers and register files in the design, replacing fixed 64 x 8 instances.

## Interface
- DATA_W, 8: word width in bits; must be a multiple of 8.
- DEPTH, 64: number of words; need not be a power of two.
- ADDR_W, $clog2(DEPTH): address width (derived; do not override).
- READ_LAT, 1: read latency in cycles; legal values are 1 or 2.
- BE_W, DATA_W/8: byte-enable width (derived).

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  single-cycle request to zero the whole array.
- busy  out  1  clear engine active; accesses are dropped while high.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  BE_W  byte enables; bit k controls wr_data[8k+7:8k].
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read data; holds its value between reads.
- rd_valid  out  1  one-cycle pulse when rd_data carries a new read result.
- err  out  1  one-cycle pulse on an out-of-range access or an access dropped while busy.

## Operation
- FSM states: ST_CLEAR and ST_RUN.
- While rst is low: state = ST_CLEAR, clear pointer = 0, busy = 1, rd_data = 0, rd_valid = 0, err = 0, read pipeline flushed. Array contents are undefined until the clear completes.
- ST_CLEAR: writes zero to mem[ptr] on each edge and increments ptr. On the edge that clears DEPTH-1, the FSM moves to ST_RUN and busy falls.
- ST_RUN, clr = 1: the FSM enters ST_CLEAR with ptr = 0 and busy = 1 from the next cycle. A write in the same cycle is still performed, and is then overwritten by the clear.
- clr while busy is ignored; the clear does not restart.
- Write, in ST_RUN with wr_en = 1 and wr_addr < DEPTH: only the enabled bytes are updated. wr_be = 0 is a legal no-op.
- Read, in ST_RUN with rd_en = 1 and rd_addr < DEPTH: the word is returned after READ_LAT cycles with rd_valid.
- Read-during-write to the same address in the same cycle is write-first:
  - enabled bytes return the new data;
  - disabled bytes return the old data.
- Out-of-range access (addr >= DEPTH):
  - a write is discarded and err pulses;
  - a read still produces rd_valid with rd_data = 0, and err pulses.
- Access with wr_en or rd_en while busy: discarded, no rd_valid, err pulses once per cycle in which either strobe is set.
- Reads and writes to different addresses in the same cycle are independent.

## Timing
- Reset clear: with rst released before edge 0, edges 0..DEPTH-1 clear words 0..DEPTH-1. busy is low after edge DEPTH-1; the first access is accepted at edge DEPTH.
- READ_LAT = 1: rd_en sampled at edge n gives rd_data/rd_valid after edge n.
- READ_LAT = 2: the result appears after edge n+1 through an output register.
- Back-to-back reads are supported at full rate: one result per cycle, in order.
- err is registered and appears after the edge that sampled the offending access.
- Reads already in the pipeline when clr is accepted still complete and return pre-clear data.
- Reset asserted mid-clear or mid-read aborts immediately; the clear restarts from word 0 after release.

## Structure
- Package ram_pkg:
  - state typedef ram_state_t {ST_CLEAR, ST_RUN};
  - constant RAM_BYTE = 8;
  - function for the range check (addr < DEPTH).
- Sub-module ram_dp_core: storage array with byte-enabled synchronous write and synchronous read, no reset on the array.
- Top level: clear FSM and pointer, write-port muxing (clear vs. user), range and busy checks, write-first bypass, READ_LAT pipeline, rd_valid and err generation.

## Test plan
- Reset release, DATA_W = 8, DEPTH = 64 -> busy high for exactly 64 cycles; then a read of every address returns 0x00 with one rd_valid each.
- DATA_W = 32: write 0xDEADBEEF to addr 5 with wr_be = 4'b1111, then 0x11223344 with wr_be = 4'b0101 -> read addr 5 returns 0xDE22BE44.
- Same-cycle write 0xA5 and read at addr 3, where the old value is 0x00 -> rd_data = 0xA5 at READ_LAT. Repeat with wr_be = 0 -> 0x00.
- DEPTH = 48: write addr 50, then read addr 50 -> err pulses twice, rd_data = 0x00 with rd_valid, and words 0..47 are unchanged.
- Fill all words with 0xFF, pulse clr, issue rd_en while busy -> err pulses, no rd_valid. After busy falls (64 cycles), every read returns 0x00.
- READ_LAT = 2: 10 back-to-back reads of addr 0..9, holding values 0x10..0x19 -> 10 consecutive rd_valid cycles starting 2 cycles after the first rd_en. Assert rst mid-stream -> rd_valid = 0 and rd_data = 0 immediately.
